rf_set_multi: RTL

// - Parametrised dual-read / single-write register file; next generation of the 4x4 RFSet.
// - Adds write enable, registered reads with valid flags, optional write-to-read bypass,
//   and a sequential clear engine that zeroes the array one entry per cycle.
// - Sits beside the datapath ALU: A/B feed operands, the write port takes results.

---
 rtl/rf_set_multi.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rf_set_multi.sv
// rf_set_multi: dual-read / single-write register file with a sequential clear engine.
// Reads are registered with a one-cycle latency. AV marks data captured on the previous edge.
// A CLR request zeroes the array one entry per cycle while BUSY is high.
// Optional feature macro: RF_SET_MULTI_BYPASS_EN.
//   Defined:   a same-edge write is forwarded to the read ports (write-first).
//   Undefined: the read ports return the pre-write contents (read-first).
module rf_set_multi #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    RA,
    input  logic [AW-1:0]    RB,
    input  logic             RE,
    input  logic             WE,
    input  logic [AW-1:0]    WR,
    input  logic [WIDTH-1:0] WRD,
    input  logic             CLR,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             AV,
    output logic             BUSY
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             av_q, av_d;

    logic clrAccept;
    logic wrAccept;
    logic rdAccept;
    logic bypassA;
    logic bypassB;

    // A clear request takes priority over a write or read on the same idle edge.
    // Nothing but the clear itself is accepted while the engine is running.
    assign clrAccept = (state_q == IDLE) && CLR;
    assign wrAccept  = (state_q == IDLE) && !CLR && WE;
    assign rdAccept  = (state_q == IDLE) && !CLR && RE;

`ifdef RF_SET_MULTI_BYPASS_EN
    // Write-first: forward the incoming write data to any port reading the same entry.
    assign bypassA = wrAccept && rdAccept && (WR == RA);
    assign bypassB = wrAccept && rdAccept && (WR == RB);
`else
    // Read-first: ports always see the array contents from before this edge.
    assign bypassA = 1'b0;
    assign bypassB = 1'b0;
`endif

    // State register: FSM and clear pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic. The clear walks the pointer from 0 up to the last entry.
    // It then returns to IDLE, so the pointer never wraps.
    // A CLR seen during CLEAR is ignored.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clrAccept) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                if (ptr_q == LastPtr) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // FSM outputs: BUSY is high for the whole time the clear engine owns the array.
    always_comb begin
        BUSY = (state_q == CLEAR);
    end

    // Array next state: zero one entry per clear cycle, otherwise take an accepted write.
    always_comb begin
        mem_d = mem_q;
        if (state_q == CLEAR) begin
            mem_d[ptr_q] = '0;
        end else if (wrAccept) begin
            mem_d[WR] = WRD;
        end
    end

    // Read port next state: capture on an accepted read, otherwise hold data and drop AV.
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        av_d = 1'b0;
        if (rdAccept) begin
            a_d  = bypassA ? WRD : mem_q[RA];
            b_d  = bypassB ? WRD : mem_q[RB];
            av_d = 1'b1;
        end
    end

    // Datapath registers. Reset zeroes the whole array, so a clear interrupted
    // by reset leaves nothing to resume.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            a_q  <= '0;
            b_q  <= '0;
            av_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            a_q   <= a_d;
            b_q   <= b_d;
            av_q  <= av_d;
        end
    end

    assign A  = a_q;
    assign B  = b_q;
    assign AV = av_q;

endmodule
